// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption engine: one round per clock through a shared
// SubBytes/ShiftRows/MixColumns/AddRoundKey datapath, with on-the-fly key expansion.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  plaintext+key handshake (ready only while idle)
//   data_in, key         128-bit plaintext and cipher key, byte 0 in [127:120]
//   out_valid / out_ready ciphertext handshake
//   data_out             128-bit ciphertext, held until the next completion
//   busy                 engine is not idle
module aes128_round_sequencer #(
    parameter int unsigned NR    = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise S-box substitution across the whole state
    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    // S-box on a single key word (the key-schedule SubWord)
    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return o;
    endfunction

    // Row r rotates left by r columns; byte index = row + 4*col, byte 0 at the MSB
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD_W-1:0] mix_col(input logic [WORD_W-1:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[WORD_W*c +: WORD_W] = mix_col(s[WORD_W*c +: WORD_W]);
        end
        return o;
    endfunction

    // Round constant for rounds 1..10; zero elsewhere
    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] rnd);
        case (rnd)
            CNT_W'(1):  return 8'h01;
            CNT_W'(2):  return 8'h02;
            CNT_W'(3):  return 8'h04;
            CNT_W'(4):  return 8'h08;
            CNT_W'(5):  return 8'h10;
            CNT_W'(6):  return 8'h20;
            CNT_W'(7):  return 8'h40;
            CNT_W'(8):  return 8'h80;
            CNT_W'(9):  return 8'h1b;
            CNT_W'(10): return 8'h36;
            default:    return 8'h00;
        endcase
    endfunction

    state_t             r_state;
    logic [BLK_W-1:0]   r_st;
    logic [BLK_W-1:0]   r_rk;
    logic [CNT_W-1:0]   r_round;
    logic               r_out_valid;
    logic [BLK_W-1:0]   r_data_out;
    logic               r_in_ready;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [BLK_W-1:0]   w_st_nxt;
    logic [BLK_W-1:0]   w_rk_nxt;
    logic [CNT_W-1:0]   w_round_nxt;
    logic               w_out_valid_nxt;
    logic [BLK_W-1:0]   w_data_out_nxt;

    logic [WORD_W-1:0]  w_k0, w_k1, w_k2, w_k3;
    logic [WORD_W-1:0]  w_sw;
    logic [BLK_W-1:0]   w_nk;
    logic [BLK_W-1:0]   w_sr;
    logic [BLK_W-1:0]   w_mid;
    logic [BLK_W-1:0]   w_last;

    // Next round key from the current one
    assign w_sw = sub_word({r_rk[23:0], r_rk[31:24]});
    assign w_k0 = r_rk[127:96] ^ w_sw ^ {rcon(r_round), 24'h0};
    assign w_k1 = r_rk[95:64] ^ w_k0;
    assign w_k2 = r_rk[63:32] ^ w_k1;
    assign w_k3 = r_rk[31:0]  ^ w_k2;
    assign w_nk = {w_k0, w_k1, w_k2, w_k3};

    // Shared round datapath; the final round skips MixColumns
    assign w_sr   = shift_rows(sub_bytes(r_st));
    assign w_mid  = mix_columns(w_sr) ^ w_nk;
    assign w_last = w_sr ^ w_nk;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_st_nxt        = r_st;
        w_rk_nxt        = r_rk;
        w_round_nxt     = r_round;
        w_out_valid_nxt = r_out_valid;
        w_data_out_nxt  = r_data_out;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_st_nxt    = data_in ^ key;
                    w_rk_nxt    = key;
                    w_round_nxt = CNT_W'(1);
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rk_nxt = w_nk;
                if (r_round == CNT_W'(NR)) begin
                    // Counter stays at NR so it never exceeds the round count
                    w_st_nxt        = w_last;
                    w_data_out_nxt  = w_last;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_st_nxt    = w_mid;
                    w_round_nxt = r_round + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_round_nxt     = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_rk        <= '0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_st        <= w_st_nxt;
            r_rk        <= w_rk_nxt;
            r_round     <= w_round_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_data_out  <= w_data_out_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign busy      = r_busy;

endmodule
